// File: rtl/cga_mac_seg_load_ctl.sv
// cga_mac_seg_load_ctl: arbitrates two requesters for the MAC segment
// register, sequences setup/strobe/check and reports readback status.
`timescale 1ns/1ps
module cga_mac_seg_load_ctl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned RR_MODE   = 0
) (
    input  logic             sysclk,
    input  logic             sys_rst_n,
    input  logic             REQ_A,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] DATA_B,
    output logic             ACK_A,
    output logic             ACK_B,
    output logic [WIDTH-1:0] SEG_D,
    output logic             LLDSEG,
    input  logic [WIDTH-1:0] SEG_Q,
    input  logic             SEGZN,
    output logic             BUSY,
    output logic             SEG_ZERO,
    output logic             LOAD_ERR
);

    localparam int unsigned CNT_W = 3;

    // Setup hold count must fit the 3-bit counter and be at least one cycle.
    if (SETUP_CYC == 0 || SETUP_CYC > 7) begin : g_bad_setup_cyc
        $error("SETUP_CYC must be in the range 1..7");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_CHECK  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               gnt_b_q, gnt_b_d;   // granted requester is B
    logic               rr_b_q, rr_b_d;     // B has tie priority (round-robin)
    logic               lldseg_q, lldseg_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               busy_q, busy_d;
    logic               seg_zero_q, seg_zero_d;
    logic               load_err_q, load_err_d;
    logic               pick_b;

    // Next-state, arbitration and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        gnt_b_d    = gnt_b_q;
        rr_b_d     = rr_b_q;
        seg_zero_d = seg_zero_q;
        load_err_d = load_err_q;
        pick_b     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ_A || REQ_B) begin
                    pick_b  = REQ_B && (!REQ_A || ((RR_MODE != 0) && rr_b_q));
                    gnt_b_d = pick_b;
                    rr_b_d  = !pick_b;
                    data_d  = pick_b ? DATA_B : DATA_A;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                load_err_d = (SEG_Q != data_q);
                seg_zero_d = ~SEGZN;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        lldseg_d = (state_d == S_STROBE);
        ack_a_d  = (state_d == S_CHECK) && !gnt_b_d;
        ack_b_d  = (state_d == S_CHECK) && gnt_b_d;
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any load in flight.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            gnt_b_q    <= 1'b0;
            rr_b_q     <= 1'b0;
            lldseg_q   <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            seg_zero_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            gnt_b_q    <= gnt_b_d;
            rr_b_q     <= rr_b_d;
            lldseg_q   <= lldseg_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            busy_q     <= busy_d;
            seg_zero_q <= seg_zero_d;
            load_err_q <= load_err_d;
        end
    end

    assign SEG_D    = data_q;
    assign LLDSEG   = lldseg_q;
    assign ACK_A    = ack_a_q;
    assign ACK_B    = ack_b_q;
    assign BUSY     = busy_q;
    assign SEG_ZERO = seg_zero_q;
    assign LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_cga_mac_seg_load_ctl.sv
// Testbench for cga_mac_seg_load_ctl: a cycle table on a SETUP_CYC=1 fixed
// priority instance plus directed sequences on a SETUP_CYC=3 round-robin one.
`timescale 1ns/1ps
module tb_cga_mac_seg_load_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0]       req_a, req_b;
    logic [1:0][7:0]  data_a, data_b;
    logic [1:0]       ack_a, ack_b, lld, busy, seg_zero, load_err, segzn;
    logic [1:0][7:0]  seg_d, seg_q, seg_reg, err_mask;

    int checks   = 0;
    int failures = 0;

    cga_mac_seg_load_ctl #(.WIDTH(8), .SETUP_CYC(1), .RR_MODE(0)) dut0 (
        .sysclk(clk), .sys_rst_n(rst_n[0]),
        .REQ_A(req_a[0]), .DATA_A(data_a[0]), .REQ_B(req_b[0]), .DATA_B(data_b[0]),
        .ACK_A(ack_a[0]), .ACK_B(ack_b[0]), .SEG_D(seg_d[0]), .LLDSEG(lld[0]),
        .SEG_Q(seg_q[0]), .SEGZN(segzn[0]), .BUSY(busy[0]),
        .SEG_ZERO(seg_zero[0]), .LOAD_ERR(load_err[0])
    );

    cga_mac_seg_load_ctl #(.WIDTH(8), .SETUP_CYC(3), .RR_MODE(1)) dut1 (
        .sysclk(clk), .sys_rst_n(rst_n[1]),
        .REQ_A(req_a[1]), .DATA_A(data_a[1]), .REQ_B(req_b[1]), .DATA_B(data_b[1]),
        .ACK_A(ack_a[1]), .ACK_B(ack_b[1]), .SEG_D(seg_d[1]), .LLDSEG(lld[1]),
        .SEG_Q(seg_q[1]), .SEGZN(segzn[1]), .BUSY(busy[1]),
        .SEG_ZERO(seg_zero[1]), .LOAD_ERR(load_err[1])
    );

    // Behavioural segment register: loads SEG_D on LLDSEG, readback can be corrupted.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i])   seg_reg[i] <= 8'h00;
            else if (lld[i]) seg_reg[i] <= seg_d[i];
        end
    end
    assign seg_q[0] = seg_reg[0] ^ err_mask[0];
    assign seg_q[1] = seg_reg[1] ^ err_mask[1];
    assign segzn[0] = (seg_reg[0] != 8'h00);
    assign segzn[1] = (seg_reg[1] != 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exclusivity invariants on every cycle out of reset.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n[i]) begin
                chk($sformatf("dut%0d ack_a&ack_b", i), 32'(ack_a[i] & ack_b[i]), 32'd0);
                chk($sformatf("dut%0d lld&ack", i), 32'(lld[i] & (ack_a[i] | ack_b[i])), 32'd0);
            end
        end
    end

    typedef struct {
        logic       ra;
        logic [7:0] da;
        logic       rb;
        logic [7:0] db;
        logic [7:0] mask;
        logic       lld;
        logic       aa;
        logic       ab;
        logic       busy;
        logic [7:0] sd;
        logic       sz;
        logic       le;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic ra, input logic [7:0] da, input logic rb, input logic [7:0] db,
                       input logic [7:0] mask, input logic e_lld, input logic e_aa, input logic e_ab,
                       input logic e_busy, input logic [7:0] e_sd, input logic e_sz, input logic e_le);
        vec_t v;
        v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.mask = mask;
        v.lld = e_lld; v.aa = e_aa; v.ab = e_ab; v.busy = e_busy;
        v.sd = e_sd; v.sz = e_sz; v.le = e_le;
        vt.push_back(v);
    endtask

    initial begin
        logic [23:0] order;
        logic [23:0] odata;
        int          nack;

        rst_n    = 2'b00;
        req_a    = 2'b00;
        req_b    = 2'b00;
        data_a   = '0;
        data_b   = '0;
        err_mask = '0;

        // Inputs: ra da rb db mask | expected after edge: lld aa ab busy seg_d seg_zero load_err
        // A loads 00 -> zero flag set, no error
        add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // B loads C3, readback corrupted to C2 -> LOAD_ERR
        add(1'b0, 8'h00, 1'b1, 8'hC3, 8'h01,  1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'hC3, 8'h01,  1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'hC3, 8'h01,  1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'hC3, 8'h01,  1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1);
        // Clean A load clears LOAD_ERR at its CHECK
        add(1'b1, 8'h3C, 1'b0, 8'h00, 8'h00,  1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
        add(1'b1, 8'h3C, 1'b0, 8'h00, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
        add(1'b1, 8'h3C, 1'b0, 8'h00, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
        add(1'b1, 8'h3C, 1'b0, 8'h00, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        // Both held, fixed priority: A twice; DATA_A change after grant ignored
        add(1'b1, 8'h11, 1'b1, 8'h22, 8'h00,  1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b1, 8'h22, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b1, 8'h22, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b1, 8'h22, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
        add(1'b1, 8'h44, 1'b1, 8'h22, 8'h00,  1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        add(1'b1, 8'h44, 1'b1, 8'h22, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        add(1'b1, 8'h44, 1'b1, 8'h22, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        add(1'b1, 8'h44, 1'b1, 8'h22, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
        // REQ_A dropped during SETUP: load still completes and ACKs
        add(1'b1, 8'h77, 1'b0, 8'h00, 8'h00,  1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        add(1'b0, 8'h77, 1'b0, 8'h00, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        add(1'b0, 8'h77, 1'b0, 8'h00, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        add(1'b0, 8'h77, 1'b0, 8'h00, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        add(1'b0, 8'h77, 1'b0, 8'h00, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);

        // Reset state on both instances
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst dut%0d lld", i),  32'(lld[i]), 32'd0);
            chk($sformatf("rst dut%0d ack", i),  32'(ack_a[i] | ack_b[i]), 32'd0);
            chk($sformatf("rst dut%0d busy", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst dut%0d segd", i), 32'(seg_d[i]), 32'd0);
            chk($sformatf("rst dut%0d flags", i), 32'({seg_zero[i], load_err[i]}), 32'd0);
        end
        @(negedge clk);
        rst_n = 2'b11;

        // Table on dut0
        for (int r = 0; r < vt.size(); r++) begin
            @(negedge clk);
            req_a[0]    = vt[r].ra;
            data_a[0]   = vt[r].da;
            req_b[0]    = vt[r].rb;
            data_b[0]   = vt[r].db;
            err_mask[0] = vt[r].mask;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d lld", r),   32'(lld[0]),      32'(vt[r].lld));
            chk($sformatf("row%0d ack_a", r), 32'(ack_a[0]),    32'(vt[r].aa));
            chk($sformatf("row%0d ack_b", r), 32'(ack_b[0]),    32'(vt[r].ab));
            chk($sformatf("row%0d busy", r),  32'(busy[0]),     32'(vt[r].busy));
            chk($sformatf("row%0d seg_d", r), 32'(seg_d[0]),    32'(vt[r].sd));
            chk($sformatf("row%0d zero", r),  32'(seg_zero[0]), 32'(vt[r].sz));
            chk($sformatf("row%0d err", r),   32'(load_err[0]), 32'(vt[r].le));
        end

        // dut1 round-robin: both held for three loads -> A,B,A
        @(negedge clk);
        req_a[1] = 1'b1; data_a[1] = 8'hAA;
        req_b[1] = 1'b1; data_b[1] = 8'hBB;
        order = '0;
        odata = '0;
        nack  = 0;
        for (int c = 0; c < 60 && nack < 3; c++) begin
            @(posedge clk);
            #1;
            if (ack_a[1] || ack_b[1]) begin
                order = {order[15:0], ack_a[1] ? 8'h41 : 8'h42};
                odata = {odata[15:0], seg_d[1]};
                nack++;
                if (nack == 3) begin
                    req_a[1] = 1'b0;
                    req_b[1] = 1'b0;
                end
            end
        end
        chk("rr ack count", 32'(nack), 32'd3);
        chk("rr grant order", 32'(order), 32'h00414241);
        chk("rr grant data", 32'(odata), 32'h00AABBAA);
        @(posedge clk);
        #1;
        chk("rr idle after", 32'(busy[1]), 32'd0);

        // dut1 SETUP_CYC=3: DATA_A change after grant ignored, LLDSEG three edges after grant
        @(negedge clk);
        req_a[1] = 1'b1; data_a[1] = 8'h12;
        @(posedge clk);
        #1;
        chk("s3 grant seg_d", 32'(seg_d[1]), 32'h12);
        chk("s3 grant busy", 32'(busy[1]), 32'd1);
        @(negedge clk);
        data_a[1] = 8'hFF;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("s3 edge%0d lld", k), 32'(lld[1]), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("s3 edge%0d seg_d", k), 32'(seg_d[1]), 32'h12);
        end
        @(posedge clk);
        #1;
        chk("s3 ack_a", 32'(ack_a[1]), 32'd1);
        chk("s3 ack lld", 32'(lld[1]), 32'd0);
        req_a[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("s3 idle busy", 32'(busy[1]), 32'd0);
        chk("s3 load_err", 32'(load_err[1]), 32'd0);

        // dut0 reset during STROBE aborts the load
        @(negedge clk);
        req_a[0] = 1'b1; data_a[0] = 8'h5A;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort strobe lld", 32'(lld[0]), 32'd1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("abort lld", 32'(lld[0]), 32'd0);
        chk("abort busy", 32'(busy[0]), 32'd0);
        chk("abort seg_d", 32'(seg_d[0]), 32'd0);
        chk("abort ack", 32'(ack_a[0] | ack_b[0]), 32'd0);
        req_a[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("abort no ack", 32'(ack_a[0] | ack_b[0]), 32'd0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("abort post busy", 32'(busy[0]), 32'd0);
        chk("abort post ack", 32'(ack_a[0] | ack_b[0]), 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
